// File: rtl/gptp_rx_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gptp_rx_dispatch : round-robin gPTP rx arbiter, shared decoder, buffer wr  |
// | Optional RX_TIMEOUT_EN adds wait timeouts with drop counter. Rev 1.0       |
// +----------------------------------------------------------------------------+

// Field map: [7:0] message type, then receive timestamp, then carried timestamp.
module dec_frame #(
  parameter int FRAME_W = 432,
  parameter int TS_W    = 80
) (
  input  logic [FRAME_W-1:0] frame,
  output logic [7:0]         msg_type,
  output logic [TS_W-1:0]    rx_ts,
  output logic [TS_W-1:0]    frame_ts
);
  localparam int HDR_W = 8 + 2 * TS_W;

  assign msg_type = frame[7:0];
  assign rx_ts    = frame[8 +: TS_W];
  assign frame_ts = frame[8 + TS_W +: TS_W];

  generate
    if (FRAME_W > HDR_W) begin : g_unused_tail
      logic unused_tail;
      assign unused_tail = ^frame[FRAME_W-1:HDR_W];
    end
  endgenerate
endmodule

module gptp_rx_dispatch #(
  parameter int NCH     = 2,
  parameter int FRAME_W = 432,
  parameter int TS_W    = 80,
  parameter int DEC_CYC = 2,
  parameter int TIMEOUT = 1024,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH*FRAME_W-1:0] gptp_rv_data,
  input  logic [NCH-1:0]         gptp_rv_vaild,
  output logic [NCH-1:0]         gptp_rv_ready,
  input  logic                   rx_rev_wr_v_ready,
  output logic                   rx_rev_wr_vaild,
  input  logic                   rx_rev_wr_ready,
  output logic [7:0]             rx_rev_wr_addr,
  output logic [TS_W-1:0]        rx_rev_wr_data1,
  output logic [TS_W-1:0]        rx_rev_wr_data2,
  output logic [CH_W-1:0]        rx_rev_wr_ch,
  output logic [15:0]            rx_drop_cnt
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CAPT     = 3'd1;
  localparam logic [2:0] S_DEC      = 3'd2;
  localparam logic [2:0] S_WAIT_V   = 3'd3;
  localparam logic [2:0] S_PULSE    = 3'd4;
  localparam logic [2:0] S_WAIT_ACK = 3'd5;

  localparam int              CNT_W    = (DEC_CYC > 1) ? $clog2(DEC_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEC_CYC - 1);
  localparam logic [CH_W-1:0]  PTR_RST  = CH_W'(NCH - 1);

  logic [2:0]         state_q, state_d;
  logic [CH_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [7:0]         addr_q, addr_d;
  logic [TS_W-1:0]    data1_q, data1_d, data2_q, data2_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic               wr_vaild_q, wr_vaild_d;

  logic [CH_W-1:0]    grant, hi_grant, lo_grant;
  logic               grant_any, hi_any;
  logic [FRAME_W-1:0] sel_frame;
  logic [7:0]         dec_addr;
  logic [TS_W-1:0]    dec_ts1, dec_ts2;
  logic               wait_exp;

  dec_frame #(.FRAME_W(FRAME_W), .TS_W(TS_W)) u_dec (
    .frame    (frame_q),
    .msg_type (dec_addr),
    .rx_ts    (dec_ts1),
    .frame_ts (dec_ts2)
  );

  // Prefer the lowest valid channel above the pointer, else wrap to the lowest valid.
  always_comb begin
    hi_grant  = '0;
    lo_grant  = '0;
    hi_any    = 1'b0;
    grant_any = 1'b0;
    sel_frame = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (gptp_rv_vaild[i]) begin
        if (CH_W'(i) > ptr_q) begin
          hi_grant = CH_W'(i);
          hi_any   = 1'b1;
        end
        lo_grant  = CH_W'(i);
        grant_any = 1'b1;
      end
      if (ptr_q == CH_W'(i)) sel_frame = gptp_rv_data[i*FRAME_W +: FRAME_W];
    end
    grant = hi_any ? hi_grant : lo_grant;
  end

`ifdef RX_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wait_q, wait_d, drop_q, drop_d;

  assign wait_exp    = (wait_q == WAIT_LAST);
  assign rx_drop_cnt = drop_q;

  always_comb begin
    wait_d = '0;
    drop_d = drop_q;
    if (state_d == state_q && (state_q == S_WAIT_V || state_q == S_WAIT_ACK))
      wait_d = wait_q + 16'd1;
    if (wait_exp && drop_q != 16'hFFFF &&
        ((state_q == S_WAIT_V && !rx_rev_wr_v_ready) ||
         (state_q == S_WAIT_ACK && !rx_rev_wr_ready)))
      drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q <= '0;
      drop_q <= '0;
    end else begin
      wait_q <= wait_d;
      drop_q <= drop_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT < 1);
  assign wait_exp       = 1'b0;
  assign rx_drop_cnt    = 16'd0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= PTR_RST;
      cnt_q      <= '0;
      frame_q    <= '0;
      addr_q     <= '0;
      data1_q    <= '0;
      data2_q    <= '0;
      ch_q       <= '0;
      wr_vaild_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      addr_q     <= addr_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      ch_q       <= ch_d;
      wr_vaild_q <= wr_vaild_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (grant_any) state_d = S_CAPT;
      S_CAPT:     state_d = gptp_rv_vaild[ptr_q] ? S_DEC : S_IDLE;
      S_DEC:      if (cnt_q == CNT_LAST) state_d = S_WAIT_V;
      S_WAIT_V: begin
        if (rx_rev_wr_v_ready) state_d = S_PULSE;
        else if (wait_exp)     state_d = S_IDLE;
      end
      S_PULSE:    state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (rx_rev_wr_ready || wait_exp) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    addr_d     = addr_q;
    data1_d    = data1_q;
    data2_d    = data2_q;
    ch_d       = ch_q;
    wr_vaild_d = (state_d == S_PULSE);
    case (state_q)
      S_IDLE: if (grant_any) ptr_d = grant;
      S_CAPT: begin
        cnt_d = '0;
        if (gptp_rv_vaild[ptr_q]) frame_d = sel_frame;
      end
      S_DEC: begin
        if (cnt_q == CNT_LAST) begin
          addr_d  = dec_addr;
          data1_d = dec_ts1;
          data2_d = dec_ts2;
          ch_d    = ptr_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    gptp_rv_ready = '0;
    if (state_q == S_CAPT) gptp_rv_ready[ptr_q] = 1'b1;
  end

  assign rx_rev_wr_vaild = wr_vaild_q;
  assign rx_rev_wr_addr  = addr_q;
  assign rx_rev_wr_data1 = data1_q;
  assign rx_rev_wr_data2 = data2_q;
  assign rx_rev_wr_ch    = ch_q;
endmodule
`default_nettype wire

// File: tb/tb_gptp_rx_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gptp_rx_dispatch : self-checking bench with FIFO + scoreboard model     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_gptp_rx_dispatch;
  localparam int NCH     = 2;
  localparam int FRAME_W = 432;
  localparam int TS_W    = 80;
  localparam int DEC_CYC = 2;
  localparam int TIMEOUT = 16;
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef RX_TIMEOUT_EN
  localparam int WAITN = 12;
`else
  localparam int WAITN = 20;
`endif

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [NCH*FRAME_W-1:0] gptp_rv_data;
  logic [NCH-1:0]         gptp_rv_vaild;
  logic [NCH-1:0]         gptp_rv_ready;
  logic                   rx_rev_wr_v_ready, rx_rev_wr_vaild, rx_rev_wr_ready;
  logic [7:0]             rx_rev_wr_addr;
  logic [TS_W-1:0]        rx_rev_wr_data1, rx_rev_wr_data2;
  logic [CH_W-1:0]        rx_rev_wr_ch;
  logic [15:0]            rx_drop_cnt;

  gptp_rx_dispatch #(
    .NCH(NCH), .FRAME_W(FRAME_W), .TS_W(TS_W), .DEC_CYC(DEC_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .gptp_rv_data(gptp_rv_data), .gptp_rv_vaild(gptp_rv_vaild), .gptp_rv_ready(gptp_rv_ready),
    .rx_rev_wr_v_ready(rx_rev_wr_v_ready), .rx_rev_wr_vaild(rx_rev_wr_vaild),
    .rx_rev_wr_ready(rx_rev_wr_ready), .rx_rev_wr_addr(rx_rev_wr_addr),
    .rx_rev_wr_data1(rx_rev_wr_data1), .rx_rev_wr_data2(rx_rev_wr_data2),
    .rx_rev_wr_ch(rx_rev_wr_ch), .rx_drop_cnt(rx_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              ch;
    logic [7:0]      addr;
    logic [TS_W-1:0] d1;
    logic [TS_W-1:0] d2;
  } exp_t;

  exp_t           sb_q[$];
  int             grants[$];
  int             fifo_cnt[NCH];
  int             n_tests = 0, n_fail = 0;
  int             last_grant, cyc, ready_cyc, wr_cyc, n_writes;
  logic [NCH-1:0] vld_prev;
  logic           wr_prev;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FRAME_W-1:0] rand_frame();
    logic [FRAME_W-1:0] f;
    for (int i = 0; i < FRAME_W; i++) f[i] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  // Reference decode from the frame field map.
  function automatic exp_t decode(input int ch, input logic [FRAME_W-1:0] f);
    exp_t e;
    e.ch   = ch;
    e.addr = f[7:0];
    e.d1   = f[8 +: TS_W];
    e.d2   = f[8 + TS_W +: TS_W];
    return e;
  endfunction

  // Walk the channels in rotation order after the last grant; first valid wins.
  function automatic int next_grant(input int last, input logic [NCH-1:0] v);
    int order[$];
    for (int k = 1; k <= NCH; k++) order.push_back((last + k) % NCH);
    foreach (order[j]) if (v[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic int pending();
    int s = sb_q.size();
    for (int c = 0; c < NCH; c++) s += fifo_cnt[c];
    return s;
  endfunction

  task automatic drive_valid();
    for (int c = 0; c < NCH; c++) gptp_rv_vaild[c] = (fifo_cnt[c] > 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, gptp_rv_ready, 0);
    check({tag, "_wr_vaild"}, rx_rev_wr_vaild, 0);
    check({tag, "_addr"}, rx_rev_wr_addr, 0);
    check({tag, "_data1"}, rx_rev_wr_data1, 0);
    check({tag, "_data2"}, rx_rev_wr_data2, 0);
    check({tag, "_ch"}, rx_rev_wr_ch, 0);
    check({tag, "_drop"}, rx_drop_cnt, 0);
  endtask

  // One clock: model the upstream FIFOs and score every write strobe.
  task automatic tick();
    logic [NCH-1:0] rdy_c, vld_c;
    int             g;
    exp_t           e;
    rdy_c = gptp_rv_ready;
    vld_c = gptp_rv_vaild;
    @(posedge clk);
    #1;
    if (rdy_c != 0) begin
      g = next_grant(last_grant, vld_prev);
      ready_cyc = cyc;
      check("ready_onehot", $onehot(rdy_c), 1);
      check("grant", rdy_c, (g >= 0) ? (1 << g) : 0);
      if (g >= 0) begin
        last_grant = g;
        grants.push_back(g);
        if (vld_c[g]) begin
          sb_q.push_back(decode(g, gptp_rv_data[g*FRAME_W +: FRAME_W]));
          fifo_cnt[g]--;
          gptp_rv_data[g*FRAME_W +: FRAME_W] = rand_frame();
          drive_valid();
        end
      end
    end
    cyc++;
    if (rx_rev_wr_vaild === 1'b1) begin
      wr_cyc = cyc;
      n_writes++;
      check("wr_pulse_width", wr_prev, 0);
      if (sb_q.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        e = sb_q.pop_front();
        check("wr_addr", rx_rev_wr_addr, e.addr);
        check("wr_data1", rx_rev_wr_data1, e.d1);
        check("wr_data2", rx_rev_wr_data2, e.d2);
        check("wr_ch", rx_rev_wr_ch, e.ch);
      end
    end
    wr_prev  = rx_rev_wr_vaild;
    vld_prev = vld_c;
  endtask

  task automatic check_stable(input string tag);
    if (sb_q.size() == 0) check({tag, "_pending"}, 0, 1);
    else begin
      check({tag, "_addr"}, rx_rev_wr_addr, sb_q[0].addr);
      check({tag, "_data1"}, rx_rev_wr_data1, sb_q[0].d1);
      check({tag, "_data2"}, rx_rev_wr_data2, sb_q[0].d2);
      check({tag, "_ch"}, rx_rev_wr_ch, sb_q[0].ch);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise, lows_v, lows_r;
    gptp_rv_vaild     = '0;
    rx_rev_wr_v_ready = 1'b0;
    rx_rev_wr_ready   = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      fifo_cnt[c] = 0;
      gptp_rv_data[c*FRAME_W +: FRAME_W] = rand_frame();
    end
    last_grant = NCH - 1;
    vld_prev = '0; wr_prev = 1'b0; cyc = 0; n_writes = 0; ready_cyc = -1; wr_cyc = -1;

    // Reset state
    tick(); tick();
    check_reset_outputs("reset");
    reset = 1'b1;
    tick();

    // T1: single frame latency
    rx_rev_wr_v_ready = 1'b1; rx_rev_wr_ready = 1'b1;
    fifo_cnt[0] = 1; drive_valid();
    cyc = 0; ready_cyc = -1; wr_cyc = -1; n_writes = 0;
    for (int i = 0; i < 12; i++) tick();
    check("t1_ready_cycle", ready_cyc, 1);
    check("t1_wr_cycle", wr_cyc, 3 + DEC_CYC);
    check("t1_writes", n_writes, 1);

    // T2: both channels continuously valid, from reset
    #2 reset = 1'b0; #1;
    sb_q.delete(); last_grant = NCH - 1;
    tick(); reset = 1'b1;
    fifo_cnt[0] = 2; fifo_cnt[1] = 2; drive_valid();
    grants.delete(); n_writes = 0;
    for (int i = 0; i < 80 && n_writes < 4; i++) tick();
    check("t2_writes", n_writes, 4);
    check("t2_grant_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) check("t2_order", grants[i], i % 2);
    tick(); tick();

    // Randomised traffic with randomised buffer handshakes
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < NCH; c++) fifo_cnt[c] = $urandom_range(1, 3);
      drive_valid();
      lows_v = 0; lows_r = 0;
      for (int i = 0; i < 400; i++) begin
        if (pending() == 0) break;
        rx_rev_wr_v_ready = (lows_v >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        rx_rev_wr_ready   = (lows_r >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        lows_v = rx_rev_wr_v_ready ? 0 : lows_v + 1;
        lows_r = rx_rev_wr_ready ? 0 : lows_r + 1;
        tick();
      end
      check("rand_drained", pending(), 0);
      rx_rev_wr_v_ready = 1'b1; rx_rev_wr_ready = 1'b1;
      tick(); tick(); tick();
    end

    // T3: buffer not ready for a while; outputs hold until the strobe
    rx_rev_wr_v_ready = 1'b0; rx_rev_wr_ready = 1'b1;
    fifo_cnt[1] = 1; drive_valid();
    cyc = 0; n_writes = 0; wr_cyc = -1;
    while (cyc < 6) tick();
    while (cyc < WAITN) begin
      check_stable("t3_hold");
      tick();
    end
    check_stable("t3_hold");
    check("t3_no_early_write", n_writes, 0);
    rx_rev_wr_v_ready = 1'b1; rise = cyc;
    tick();
    check("t3_wr_cycle", wr_cyc, rise + 1);
    check("t3_writes", n_writes, 1);
    tick(); tick();

    // T4: reset during decode
    fifo_cnt[0] = 1; drive_valid();
    cyc = 0;
    tick(); tick();
    #2 reset = 1'b0; #1;
    check_reset_outputs("t4_reset");
    sb_q.delete(); last_grant = NCH - 1; n_writes = 0;
    fifo_cnt[0] = 1; fifo_cnt[1] = 1; drive_valid();
    tick(); tick();
    check("t4_no_write_in_reset", n_writes, 0);
    reset = 1'b1;
    grants.delete();
    for (int i = 0; i < 40 && n_writes < 2; i++) tick();
    check("t4_writes", n_writes, 2);
    check("t4_first_grant", (grants.size() > 0) ? grants[0] : -1, 0);
    tick(); tick();

    // T5: valid withdrawn during capture
    fifo_cnt[1] = 1; drive_valid();
    n_writes = 0; grants.delete();
    tick();
    fifo_cnt[1] = 0; drive_valid();
    for (int i = 0; i < 10; i++) tick();
    check("t5_no_write", n_writes, 0);
    check("t5_grant_seen", grants.size(), 1);
    fifo_cnt[0] = 1; drive_valid();
    for (int i = 0; i < 20 && n_writes < 1; i++) tick();
    check("t5_recover_write", n_writes, 1);
    tick(); tick();

`ifdef RX_TIMEOUT_EN
    // T6: acknowledge never arrives
    rx_rev_wr_v_ready = 1'b1; rx_rev_wr_ready = 1'b0;
    fifo_cnt[0] = 1; drive_valid();
    cyc = 0; wr_cyc = -1;
    while (cyc < 21) tick();
    check("t6_wr_cycle", wr_cyc, 3 + DEC_CYC);
    check("t6_drop_before", rx_drop_cnt, 0);
    tick();
    check("t6_drop_after", rx_drop_cnt, 1);
    rx_rev_wr_ready = 1'b1;
    tick();
`else
    check("drop_tied_zero", rx_drop_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
